// File: rtl/req_encoder_32to5_pkg.sv
// Shared types and constants for the 32-to-5 request encoder.
package enc_pkg;

    localparam int N_REQ = 32;
    localparam int IDX_W = 5;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [N_REQ-1:0] reqvec_t;

    function automatic reqvec_t onehot(idx_t i);
        reqvec_t v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/req_encoder_32to5_if.sv
// Request/handshake bundle between event sources, the encoder and its consumer.
interface req_encoder_32to5_if;
    import enc_pkg::*;

    reqvec_t req;
    logic    clr;
    idx_t    code;
    logic    valid;
    logic    ready;
    reqvec_t pending;
    logic    overflow;

    modport slave (
        input  req, clr, ready,
        output code, valid, pending, overflow
    );

    modport master (
        output req, clr, ready,
        input  code, valid, pending, overflow
    );

endinterface

// File: rtl/req_encoder_32to5_pick.sv
// Combinational find-first-set starting at i_start and wrapping 31 -> 0.
module pick_first32
    import enc_pkg::*;
(
    input  reqvec_t i_vec,
    input  idx_t    i_start,
    output idx_t    o_idx,
    output logic    o_found
);

    logic [2*N_REQ-1:0] w_dbl;
    reqvec_t            w_rot;
    idx_t               w_off;

    // Rotate so that bit i_start lands at position 0, then search upward.
    assign w_dbl = {i_vec, i_vec} >> i_start;
    assign w_rot = w_dbl[N_REQ-1:0];

    always_comb begin
        w_off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = idx_t'(i);
            end
        end
    end

    assign o_found = |i_vec;
    assign o_idx   = w_off + i_start;

endmodule

// File: rtl/req_encoder_32to5.sv
// Captures request pulses into a pending vector and presents one index at a time
// under valid/ready, using fixed-priority (RR=0) or round-robin (RR=1) selection.
module req_encoder_32to5
    import enc_pkg::*;
#(
    parameter bit RR = 1'b1
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    req_encoder_32to5_if.slave   bus
);

    reqvec_t r_pending;
    logic    r_valid;
    idx_t    r_code;
    idx_t    r_ptr;
    logic    r_overflow;

    logic    w_acc;
    logic    w_load;
    reqvec_t w_acc_mask;
    reqvec_t w_sel_src;
    reqvec_t w_pending_next;
    logic    w_ovf_hit;
    idx_t    w_start;
    idx_t    w_pick;
    logic    w_found;

    assign w_acc          = r_valid & bus.ready;
    assign w_acc_mask     = w_acc ? onehot(r_code) : '0;
    assign w_sel_src      = r_pending & ~w_acc_mask;
    assign w_pending_next = w_sel_src | bus.req;
    // A request landing on the index being accepted re-arms it, so it is not an overflow.
    assign w_ovf_hit      = |(bus.req & w_sel_src);
    assign w_load         = ~r_valid | w_acc;
    assign w_start        = RR ? r_ptr : '0;

    pick_first32 u_pick (
        .i_vec   (w_sel_src),
        .i_start (w_start),
        .o_idx   (w_pick),
        .o_found (w_found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending  <= '0;
            r_valid    <= 1'b0;
            r_code     <= '0;
            r_ptr      <= '0;
            r_overflow <= 1'b0;
        end else if (bus.clr) begin
            r_pending  <= '0;
            r_valid    <= 1'b0;
            r_code     <= '0;
            r_ptr      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_pending  <= w_pending_next;
            r_overflow <= r_overflow | w_ovf_hit;
            // A stalled code is never replaced, even by a higher-priority arrival.
            if (w_load) begin
                r_valid <= w_found;
                if (w_found) begin
                    r_code <= w_pick;
                end
            end
            if (RR && w_acc) begin
                r_ptr <= r_code + 5'd1;
            end
        end
    end

    assign bus.code     = r_code;
    assign bus.valid    = r_valid;
    assign bus.pending  = r_pending;
    assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_req_encoder_32to5.sv
// Drives a fixed-priority and a round-robin encoder with identical stimulus and
// checks both against a queue-free behavioural model plus directed vectors.
module tb_req_encoder_32to5;
    import enc_pkg::*;

    logic clk;
    logic rst_n;

    req_encoder_32to5_if fp_if ();
    req_encoder_32to5_if rr_if ();

    req_encoder_32to5 #(.RR(1'b0)) dut_fp (.clk(clk), .rst_n(rst_n), .bus(fp_if.slave));
    req_encoder_32to5 #(.RR(1'b1)) dut_rr (.clk(clk), .rst_n(rst_n), .bus(rr_if.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state, index 0 = fixed priority, 1 = round robin.
    reqvec_t m_pend [2];
    logic    m_valid[2];
    int      m_code [2];
    int      m_ptr  [2];
    logic    m_ovf  [2];

    reqvec_t cur_req;
    logic    cur_rdy;
    logic    cur_clr;

    typedef struct {
        reqvec_t req;
        logic    rdy;
        logic    clr;
        logic    v;
        idx_t    code;
        reqvec_t pend;
        logic    ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void model_clear(int m);
        m_pend[m]  = '0;
        m_valid[m] = 1'b0;
        m_code[m]  = 0;
        m_ptr[m]   = 0;
        m_ovf[m]   = 1'b0;
    endfunction

    function automatic void model_step(int m, reqvec_t req, logic rdy, logic clr);
        reqvec_t src;
        bit      acc;
        int      pick;
        int      idx;
        int      new_ptr;
        if (clr) begin
            model_clear(m);
            return;
        end
        acc     = m_valid[m] && rdy;
        src     = m_pend[m];
        new_ptr = m_ptr[m];
        if (acc) begin
            src[m_code[m]] = 1'b0;
            if (m == 1) new_ptr = (m_code[m] + 1) % 32;
        end
        if ((req & src) != 0) m_ovf[m] = 1'b1;
        if (!m_valid[m] || acc) begin
            pick = -1;
            for (int k = 0; k < 32; k++) begin
                idx = (m_ptr[m] + k) % 32;
                if (pick < 0 && src[idx]) pick = idx;
            end
            m_valid[m] = (pick >= 0);
            if (pick >= 0) m_code[m] = pick;
        end
        m_pend[m] = src | req;
        m_ptr[m]  = new_ptr;
    endfunction

    task automatic drive(reqvec_t r, logic rdy, logic c);
        cur_req = r;  cur_rdy = rdy;  cur_clr = c;
        fp_if.req = r;  fp_if.ready = rdy;  fp_if.clr = c;
        rr_if.req = r;  rr_if.ready = rdy;  rr_if.clr = c;
    endtask

    task automatic cmp_model();
        check("fp.valid",    32'(fp_if.valid),    32'(m_valid[0]));
        check("fp.code",     32'(fp_if.code),     32'(m_code[0]));
        check("fp.pending",  fp_if.pending,       m_pend[0]);
        check("fp.overflow", 32'(fp_if.overflow), 32'(m_ovf[0]));
        check("rr.valid",    32'(rr_if.valid),    32'(m_valid[1]));
        check("rr.code",     32'(rr_if.code),     32'(m_code[1]));
        check("rr.pending",  rr_if.pending,       m_pend[1]);
        check("rr.overflow", 32'(rr_if.overflow), 32'(m_ovf[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, cur_req, cur_rdy, cur_clr);
        model_step(1, cur_req, cur_rdy, cur_clr);
        #1;
        cmp_model();
    endtask

    task automatic check_all_zero(string tag);
        check({tag, ".fp.valid"},    32'(fp_if.valid),    32'd0);
        check({tag, ".fp.code"},     32'(fp_if.code),     32'd0);
        check({tag, ".fp.pending"},  fp_if.pending,       32'd0);
        check({tag, ".fp.overflow"}, 32'(fp_if.overflow), 32'd0);
        check({tag, ".rr.valid"},    32'(rr_if.valid),    32'd0);
        check({tag, ".rr.pending"},  rr_if.pending,       32'd0);
    endtask

    function automatic void add(reqvec_t r, logic rdy, logic c, logic v, idx_t code,
                                reqvec_t p, logic o);
        vec_t e;
        e.req = r; e.rdy = rdy; e.clr = c; e.v = v; e.code = code; e.pend = p; e.ovf = o;
        tbl.push_back(e);
    endfunction

    initial begin
        // Directed vectors for the fixed-priority instance: inputs for one cycle,
        // then expected outputs after that edge.
        add(32'h0000_0010, 1, 0, 0,  0, 32'h0000_0010, 0);
        add(32'h0000_0000, 1, 0, 1,  4, 32'h0000_0010, 0);
        add(32'h0000_0000, 1, 0, 0,  4, 32'h0000_0000, 0);
        add(32'h8000_0005, 0, 0, 0,  4, 32'h8000_0005, 0);
        for (int i = 0; i < 5; i++) add(32'h0, 0, 0, 1, 0, 32'h8000_0005, 0);
        add(32'h0000_0000, 1, 0, 1,  2, 32'h8000_0004, 0);
        add(32'h0000_0000, 1, 0, 1, 31, 32'h8000_0000, 0);
        add(32'h0000_0000, 1, 0, 0, 31, 32'h0000_0000, 0);
        add(32'h0000_0200, 0, 0, 0, 31, 32'h0000_0200, 0);
        add(32'h0000_0000, 0, 0, 1,  9, 32'h0000_0200, 0);
        add(32'h0000_0008, 0, 0, 1,  9, 32'h0000_0208, 0);
        add(32'h0000_0000, 0, 0, 1,  9, 32'h0000_0208, 0);
        add(32'h0000_0000, 1, 0, 1,  3, 32'h0000_0008, 0);
        add(32'h0000_0000, 1, 0, 0,  3, 32'h0000_0000, 0);
        add(32'h0000_0080, 1, 0, 0,  3, 32'h0000_0080, 0);
        add(32'h0000_0000, 1, 0, 1,  7, 32'h0000_0080, 0);
        add(32'h0000_0080, 1, 0, 0,  7, 32'h0000_0080, 0);
        add(32'h0000_0000, 1, 0, 1,  7, 32'h0000_0080, 0);
        add(32'h0000_0000, 1, 0, 0,  7, 32'h0000_0000, 0);
        add(32'h0000_0080, 0, 0, 0,  7, 32'h0000_0080, 0);
        add(32'h0000_0080, 0, 0, 1,  7, 32'h0000_0080, 1);
        add(32'h0000_0000, 0, 0, 1,  7, 32'h0000_0080, 1);
        add(32'h0000_0000, 1, 0, 0,  7, 32'h0000_0000, 1);
        add(32'h0000_0000, 1, 1, 0,  0, 32'h0000_0000, 0);

        rst_n = 1'b0;
        drive('0, 1'b0, 1'b0);
        model_clear(0);
        model_clear(1);
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].req, tbl[i].rdy, tbl[i].clr);
            tick();
            check($sformatf("tbl%0d.valid", i),    32'(fp_if.valid),    32'(tbl[i].v));
            check($sformatf("tbl%0d.code", i),     32'(fp_if.code),     32'(tbl[i].code));
            check($sformatf("tbl%0d.pending", i),  fp_if.pending,       tbl[i].pend);
            check($sformatf("tbl%0d.overflow", i), 32'(fp_if.overflow), 32'(tbl[i].ovf));
        end

        // Round-robin wrap: accepting 30 moves the pointer to 31, then {31,1} pend.
        drive(32'h4000_0000, 1, 0); tick();
        drive(32'h0, 1, 0);         tick();
        check("rrwrap.code30", 32'(rr_if.code), 32'd30);
        drive(32'h8000_0002, 1, 0); tick();
        check("rrwrap.gap", 32'(rr_if.valid), 32'd0);
        drive(32'h0, 1, 0);         tick();
        check("rrwrap.first31", 32'(rr_if.code), 32'd31);
        check("fp.first1",      32'(fp_if.code), 32'd1);
        tick();
        check("rrwrap.then1", 32'(rr_if.code), 32'd1);
        check("rrwrap.valid", 32'(rr_if.valid), 32'd1);
        check("fp.then31",    32'(fp_if.code), 32'd31);
        tick();
        check("rrwrap.empty", 32'(rr_if.valid), 32'd0);

        // Asynchronous reset while a code is presented and stalled.
        drive(32'h0000_00ff, 0, 0); tick();
        drive(32'h0, 0, 0);         tick();
        check("arst.pre_valid", 32'(fp_if.valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("arst");
        model_clear(0);
        model_clear(1);
        drive(32'h0, 1, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("arst.no_codes", 32'(fp_if.valid | rr_if.valid), 32'd0);
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 800; i++) begin
            reqvec_t r;
            r = ($urandom_range(0, 2) == 0) ? reqvec_t'($urandom & $urandom & $urandom) : '0;
            drive(r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/req_encoder_32to5.md
# req_encoder_32to5

Sequential 32-to-5 request encoder: the inverse of the 5-to-32 one-hot select decoder. It captures single-cycle request pulses on 32 lines into a pending register and presents one pending index at a time as a 5-bit code under a valid/ready handshake. Arbitration is fixed-priority or round-robin. It sits between event sources (interrupt lines, register-file write-back requests) and a consumer that accepts one index per cycle.

## Interface
- `RR`, default 1: 1 selects round-robin arbitration; 0 selects fixed priority, lowest index wins.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  32: request pulses. Bit i high in a cycle marks index i pending.
- `clr`  in  1: synchronous clear of all state.
- `code`  out  5: index of the presented request.
- `valid`  out  1: `code` is valid.
- `ready`  in  1: the consumer accepts `code` this cycle.
- `pending`  out  32: registered pending vector.
- `overflow`  out  1: sticky flag. Set when a request arrives for an index that is already pending.

## Operation
- Reset (`rst_n`=0, asynchronous) drives the following values:
  - `pending`=0
  - `valid`=0
  - `code`=0
  - `overflow`=0
  - round-robin pointer `ptr`=0
- `clr`=1 forces the same values at the next edge. `clr` has priority over every other input in that cycle.
- Accept condition: `acc` = `valid` & `ready`.
- Pending update: `pending_next` = (`pending` & ~(`acc` ? onehot(`code`) : 0)) | `req`.
  - A request on an index in the same cycle that index is accepted re-arms that index. It counts as a new event, not an overflow.
- Overflow: set when (`req` & `pending` & ~accepted_mask) ≠ 0. It stays set until `clr` or reset.
- Selection source: `sel_src` = `pending` & ~(`acc` ? onehot(`code`) : 0). `req` from the current cycle is not included.
- Pick rule:
  - `RR`=0: lowest set index of `sel_src`.
  - `RR`=1: first set index at or above `ptr`, searching upward and wrapping 31→0.
- Output register loads when `valid`=0 or `acc`=1:
  - `valid` ← (`sel_src` ≠ 0).
  - `code` ← picked index. When nothing is picked, `code` holds its old value.
- While `valid`=1 and `ready`=0, `code` and `valid` must stay stable. New higher-priority requests must not preempt the presented code.
- On `acc` with `RR`=1, `ptr` ← `code`+1 mod 32, so 31 wraps to 0. `ptr` is unused when `RR`=0.
- `ready` is ignored while `valid`=0.

## Timing
- Latency: `req` bit high in cycle k sets `pending` at edge k+1. `valid`/`code` reflect it at edge k+2, provided the output register is free.
- Throughput: one accept per cycle with `ready` held high. There are no bubbles between back-to-back pending indices.
- The last pending index accepted at edge e gives `valid`=0 after edge e, unless a `req` arrived in cycle e-1.
- When `rst_n` is asserted mid-handshake, `valid` drops immediately and no accept is recorded.
- After `rst_n` deasserts, the first edge samples normally.
- Outputs are purely registered. There is no combinational path from `req` or `ready` to any output.

## Structure
- Shared package `enc_pkg`:
  - `N_REQ`=32
  - `IDX_W`=5
  - typedef `idx_t` (5-bit)
  - typedef `reqvec_t` (32-bit)
- Sub-module `pick_first32`: a combinational rotate-by-`ptr` find-first-set. Inputs are the 32-bit vector and the 5-bit start index; outputs are the 5-bit index and a `found` bit. With `RR`=0 it is instantiated with start tied to 0.
- The top level holds the pending register, output register, pointer, and overflow flag.

## Test plan
- Reset and single request: hold `rst_n` low, check every output is 0. Release, pulse `req`=0x0000_0010 for one cycle with `ready`=1 → `valid`=1, `code`=4 two edges later. The accept is taken that cycle, `valid`=0 after it, `pending`=0.
- Fixed priority (`RR`=0), backpressure: pulse `req`=0x8000_0005 with `ready`=0 → `code`=0, held stable for 5 cycles. Then raise `ready` → codes 0, 2, 31 on consecutive cycles, then `valid`=0.
- Round-robin wrap (`RR`=1): set `ptr` to 31 by accepting index 30, then pend {31, 1} → order 31, then 1.
- Stability under preemption (`RR`=0): while `code`=9 is stalled, pulse `req` bit 3 → `code` stays 9 until accepted, then 3 is presented next.
- Overflow and re-arm:
  - `req` bit 7 twice while 7 is pending and unaccepted → `overflow`=1 and sticky.
  - `req` bit 7 in the accept cycle of `code`=7 → 7 is presented again, `overflow` is unchanged.
  - `clr` → all outputs 0.
- Asynchronous reset mid-stream: assert `rst_n` low between edges while `valid`=1 → `valid`=0 immediately and `pending`=0, with no further codes after release.
